proc_driver: RTL
================

// Module: proc_driver
// PURPOSE
//   Host-side companion to the attention processor: the other end of its start/done vector interface.
//   - Receives one job as a serial beat stream: MATRIX_SIZE A operands, then MATRIX_SIZE B operands.
//   - Presents both vectors to the processor and pulses proc_start.
//   - Waits for proc_done, captures the result vector and streams it back out one beat per word.
//   - Sits between the AXI wrapper's stream FIFOs and the processor core.
// PARAMETERS
//   DATA_WIDTH      16    operand/result word width
//   MATRIX_SIZE     16    words per vector (A, B and result)
//   TIMEOUT_CYCLES  1024  max cycles in WAIT_DONE before abort; 0 disables the timeout
// PORTS
//   clk            in   1                      clock
//   rst            in   1                      synchronous, active-high reset
//   cfg_mode       in   2                      op for next job; sampled on first accepted beat of FILL_A
//   s_valid        in   1                      input beat valid
//   s_ready        out  1                      input beat ready
//   s_data         in   DATA_WIDTH             input beat
//   m_valid        out  1                      result beat valid
//   m_ready        in   1                      result beat ready
//   m_data         out  DATA_WIDTH             result beat
//   m_last         out  1                      high on final result beat (index MATRIX_SIZE-1)
//   proc_start     out  1                      one-cycle start pulse to processor
//   proc_mode      out  2                      latched cfg_mode; stable from START through WAIT_DONE
//   proc_a         out  DATA_WIDTH x MATRIX_SIZE   A vector; stable from START through WAIT_DONE
//   proc_b         out  DATA_WIDTH x MATRIX_SIZE   B vector; stable from START through WAIT_DONE
//   proc_data_out  in   DATA_WIDTH x MATRIX_SIZE   processor result vector
//   proc_done      in   1                      result valid; one-cycle pulse
//   busy           out  1                      high in any state other than IDLE
//   timeout_err    out  1                      sticky abort flag; cleared on first beat of next job
// BEHAVIOUR
//   Reset values (rst sampled high on a clk edge)
//   - State = IDLE; idx = 0; timeout counter = 0.
//   - s_ready = 0, m_valid = 0, m_last = 0, m_data = 0, proc_start = 0, proc_mode = 0,
//     busy = 0, timeout_err = 0.
//   - proc_a, proc_b and the result buffer are cleared to 0.
//   - Reset mid-job aborts the job immediately; no partial output is emitted.
//   State machine
//   - IDLE: s_ready = 1. On s_valid: proc_a[0] <= s_data, proc_mode <= cfg_mode, timeout_err <= 0,
//     idx <= 1, go to FILL_A. (The IDLE accept counts as the first FILL_A beat.)
//   - FILL_A: s_ready = 1. Each handshake writes proc_a[idx] and increments idx.
//     After beat MATRIX_SIZE-1, idx <= 0 and go to FILL_B.
//   - FILL_B: same rule, writing proc_b. After the last beat, go to START.
//   - START: s_ready = 0; proc_start = 1 for exactly this cycle; go to WAIT_DONE.
//   - WAIT_DONE: count cycles.
//     - On proc_done: capture all of proc_data_out into the result buffer; idx <= 0; go to DRAIN.
//     - If the count reaches TIMEOUT_CYCLES (nonzero) with no proc_done: timeout_err <= 1; go to IDLE.
//     - If proc_done coincides with the expiry cycle, proc_done wins.
//   - DRAIN: m_valid = 1, m_data = buf[idx], m_last = (idx == MATRIX_SIZE-1).
//     - On m_valid && m_ready: idx++.
//     - On the last-beat handshake: go to IDLE.
//     - While m_ready = 0, m_valid/m_data/m_last hold stable.
//   Handshake and timing
//   - A beat transfers on any cycle where valid && ready; no combinational path from m_ready to m_valid.
//   - proc_done outside WAIT_DONE is ignored.
//   - Idle gaps on s_valid stall the fill without loss.
//   - Minimum latency, last B beat to proc_start: 1 cycle.
//   - Minimum latency, proc_done to first m_valid: 1 cycle.
//   - Back-to-back jobs: input is not accepted until DRAIN completes (single-buffered).
//   - idx width = $clog2(MATRIX_SIZE)+1; the timeout counter saturates and never wraps.
// TESTING
//   1. MATRIX_SIZE=16, cfg_mode=00; feed A=1..16, B=17..32; processor model returns A*B after 5 cycles
//      -> proc_start pulses once; proc_a[15]=16, proc_b[0]=17; output 16 beats of products,
//      m_last only on beat 16.
//   2. Output backpressure: m_ready toggles 1,0,0,1 repeatedly
//      -> every word appears exactly once, in order, stable while stalled; busy drops after the last beat.
//   3. Input gaps: s_valid low every 3rd cycle
//      -> the same vectors load; proc_start is issued exactly 1 cycle after the 32nd accepted beat.
//   4. TIMEOUT_CYCLES=8, processor never asserts done
//      -> timeout_err=1 exactly 8 cycles after proc_start; state IDLE; no m_valid.
//      -> Next job's first beat clears the flag.
//   5. rst asserted during DRAIN at beat 5
//      -> the next cycle shows m_valid=0, busy=0, all outputs at reset values.
//      -> A fresh job then completes normally.
//   6. proc_done pulsed during FILL_B, then again in WAIT_DONE; cfg_mode changed mid-fill to 11
//      -> the first pulse is ignored; proc_mode stays at the value sampled on beat 1.

Source files
------------

// File: rtl/proc_driver_if.sv
// ----------------------------------------------------------------------------
// proc_driver_if
//   Bundles every signal between proc_driver and its environment: the
//   input beat stream, the result beat stream, the processor start/done
//   vector interface and the job status flags.
//   Ports summary (driver view = slave modport):
//     cfg_mode       in   op for next job
//     s_valid/s_data in,  s_ready out        input beat stream
//     m_valid/m_data/m_last out, m_ready in  result beat stream
//     proc_start/proc_mode/proc_a/proc_b out processor request
//     proc_data_out/proc_done in             processor result
//     busy/timeout_err out                   status
//   master = host/processor side, slave = proc_driver.
// ----------------------------------------------------------------------------
interface proc_driver_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int MATRIX_SIZE = 16
);
    logic [1:0]                             cfg_mode;
    logic                                   s_valid;
    logic                                   s_ready;
    logic [DATA_WIDTH-1:0]                  s_data;
    logic                                   m_valid;
    logic                                   m_ready;
    logic [DATA_WIDTH-1:0]                  m_data;
    logic                                   m_last;
    logic                                   proc_start;
    logic [1:0]                             proc_mode;
    logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] proc_a;
    logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] proc_b;
    logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] proc_data_out;
    logic                                   proc_done;
    logic                                   busy;
    logic                                   timeout_err;

    modport master (
        output cfg_mode, s_valid, s_data, m_ready, proc_data_out, proc_done,
        input  s_ready, m_valid, m_data, m_last, proc_start, proc_mode,
               proc_a, proc_b, busy, timeout_err
    );

    modport slave (
        input  cfg_mode, s_valid, s_data, m_ready, proc_data_out, proc_done,
        output s_ready, m_valid, m_data, m_last, proc_start, proc_mode,
               proc_a, proc_b, busy, timeout_err
    );
endinterface

// File: rtl/proc_driver.sv
// ----------------------------------------------------------------------------
// proc_driver
//   Host-side companion to the attention processor. Collects one job as a
//   serial stream (MATRIX_SIZE A words then MATRIX_SIZE B words), presents
//   both vectors and pulses proc_start, waits for proc_done (with optional
//   timeout), then streams the captured result vector back one word per beat.
//   Ports:
//     clk   in  clock
//     rst   in  synchronous active-high reset
//     bus   slave modport of proc_driver_if (streams, processor I/F, status)
// ----------------------------------------------------------------------------
module proc_driver #(
    parameter int DATA_WIDTH     = 16,
    parameter int MATRIX_SIZE    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    proc_driver_if.slave bus
);
    localparam int IW = $clog2(MATRIX_SIZE) + 1;
    localparam int AW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [IW-1:0] LAST = IW'(MATRIX_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL_A,
        FILL_B,
        START,
        WAIT_DONE,
        DRAIN
    } state_t;

    state_t                                 state_q;
    logic [IW-1:0]                          idx_q;
    logic [CW-1:0]                          cnt_q;
    logic                                   s_ready_q;
    logic                                   m_valid_q;
    logic                                   m_last_q;
    logic [DATA_WIDTH-1:0]                  m_data_q;
    logic                                   start_q;
    logic [1:0]                             mode_q;
    logic                                   busy_q;
    logic                                   terr_q;
    logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] a_q;
    logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] b_q;
    logic [MATRIX_SIZE-1:0][DATA_WIDTH-1:0] res_q;

    logic [IW-1:0] idx_nx;
    logic          s_hs;
    logic          expired;

    always_comb begin
        idx_nx  = idx_q + IW'(1);
        s_hs    = s_ready_q && bus.s_valid;
        // cnt_q holds cycles elapsed since the proc_start cycle
        expired = (TIMEOUT_CYCLES != 0) && ((int'(cnt_q) + 1) >= TIMEOUT_CYCLES);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            start_q   <= 1'b0;
            mode_q    <= '0;
            busy_q    <= 1'b0;
            terr_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // s_ready rises one cycle after reset, then stays up while idle
                    s_ready_q <= 1'b1;
                    if (s_hs) begin
                        a_q[0] <= bus.s_data;
                        mode_q <= bus.cfg_mode;
                        terr_q <= 1'b0;
                        busy_q <= 1'b1;
                        if (MATRIX_SIZE == 1) begin
                            idx_q   <= '0;
                            state_q <= FILL_B;
                        end else begin
                            idx_q   <= IW'(1);
                            state_q <= FILL_A;
                        end
                    end
                end
                FILL_A: begin
                    if (s_hs) begin
                        a_q[idx_q[AW-1:0]] <= bus.s_data;
                        if (idx_q == LAST) begin
                            idx_q   <= '0;
                            state_q <= FILL_B;
                        end else begin
                            idx_q <= idx_nx;
                        end
                    end
                end
                FILL_B: begin
                    if (s_hs) begin
                        b_q[idx_q[AW-1:0]] <= bus.s_data;
                        if (idx_q == LAST) begin
                            idx_q     <= '0;
                            s_ready_q <= 1'b0;
                            start_q   <= 1'b1;
                            state_q   <= START;
                        end else begin
                            idx_q <= idx_nx;
                        end
                    end
                end
                START: begin
                    cnt_q   <= CW'(1);
                    state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // done takes priority over a coinciding expiry
                    if (bus.proc_done) begin
                        res_q     <= bus.proc_data_out;
                        idx_q     <= '0;
                        m_valid_q <= 1'b1;
                        m_data_q  <= bus.proc_data_out[0];
                        m_last_q  <= (MATRIX_SIZE == 1);
                        state_q   <= DRAIN;
                    end else if (expired) begin
                        terr_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        s_ready_q <= 1'b1;
                        idx_q     <= '0;
                        state_q   <= IDLE;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DRAIN: begin
                    if (bus.m_ready) begin
                        if (m_last_q) begin
                            m_valid_q <= 1'b0;
                            m_last_q  <= 1'b0;
                            busy_q    <= 1'b0;
                            s_ready_q <= 1'b1;
                            idx_q     <= '0;
                            state_q   <= IDLE;
                        end else begin
                            idx_q    <= idx_nx;
                            m_data_q <= res_q[idx_nx[AW-1:0]];
                            m_last_q <= (idx_nx == LAST);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.s_ready     = s_ready_q;
    assign bus.m_valid     = m_valid_q;
    assign bus.m_data      = m_data_q;
    assign bus.m_last      = m_last_q;
    assign bus.proc_start  = start_q;
    assign bus.proc_mode   = mode_q;
    assign bus.proc_a      = a_q;
    assign bus.proc_b      = b_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = terr_q;
endmodule
